// File: rtl/hack_pkg.sv
// Shared Hack CPU helper definitions: machine word width and multiplier FSM states.
package hack_pkg;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/Add16.sv
// Ripple-carry adder of the Hack datapath; the carry-out is not produced since
// every user works modulo 2^W.
module Add16
    import hack_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum
);
    logic [W-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i] = x[i] ^ y[i] ^ carry[i];
        if (i < W - 1) begin : g_carry
            assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
    end
endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-and-add multiplier returning the low WIDTH bits of a*b,
// one partial product per clock through a single shared Add16.
module mul16_seq
    import hack_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and
    // out/out_valid stay stable until out_ready is seen.
    mul_state_t       state, state_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_step;

    Add16 #(.W(WIDTH)) u_add (
        .x   (acc),
        .y   (mcand),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        // Early exit fires once no set multiplier bits remain above the current one.
        last_step  = (cnt == CNT_W'(WIDTH - 1)) ||
                     (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (mplier[0]) begin
                    acc_nxt = sum;
                end
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CNT_W'(1);
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out       = acc;
endmodule
